// File: rtl/alu_control_regfile_pkg.sv
// Shared constants and types for the single-cycle RV32I integer ALU with its register file.
// Holds the opcode constants, the ALU operation enum and the funct3-to-operation mapping.
package alu_control_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // Default operation for a funct3 value; the funct7 alternates (SUB, SRA) are chosen by the decoder.
  function automatic alu_op_e f3_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_regfile_if.sv
// Instruction/result/debug bundle between the ALU-regfile block and whatever drives it.
// Instructions arrive one per cycle with no handshake: every clock edge consumes inst.
interface alu_control_regfile_if;
  import alu_control_pkg::*;

  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] rd_data;
  logic            rd_we;
  logic            halted;
  logic [4:0]      dbg_num;
  logic [XLEN-1:0] dbg_data;

  modport master (
    output inst, dbg_num,
    input  rd_data, rd_we, halted, dbg_data
  );

  modport slave (
    input  inst, dbg_num,
    output rd_data, rd_we, halted, dbg_data
  );

endinterface

// File: rtl/alu_regfile_array.sv
// 32x32 register storage: two combinational read ports, one debug read port, one write port.
// Reads see the pre-edge contents; x0 is never written and always reads zero.
module alu_regfile_array
  import alu_control_pkg::*;
(
  input  logic            clk,
  input  logic            rst_b,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic [XLEN-1:0] dbg_data_o,
  input  logic            we_i,
  input  logic [4:0]      wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wr_addr_i != 5'd0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regs_q[rs1_addr_i];
  assign rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regs_q[rs2_addr_i];
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_control_regfile.sv
// Single-cycle RV32I OP / OP-IMM executor: decode, ALU and register file, with a sticky
// halt raised by any SYSTEM opcode (ECALL/EBREAK) that blocks all further writes.
module alu_control_regfile
  import alu_control_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_b,
  alu_control_regfile_if.slave bus
);

  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [6:0] funct7;

  assign opcode = bus.inst[6:0];
  assign rd     = bus.inst[11:7];
  assign funct3 = bus.inst[14:12];
  assign rs1    = bus.inst[19:15];
  assign rs2    = bus.inst[24:20];
  assign funct7 = bus.inst[31:25];

  logic            halted_q, halted_d;
  logic            dec_legal;
  logic            dec_use_imm;
  alu_op_e         dec_op;
  logic            f7_base, f7_alt;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] op_a, op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;

  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);
  assign imm     = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};

  // funct7 must be exactly 0x00, or 0x20 where an alternate exists (SUB, SRA/SRAI).
  always_comb begin
    dec_legal   = 1'b0;
    dec_use_imm = 1'b0;
    dec_op      = ALU_ADD;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          3'd0: begin
            dec_legal = f7_base | f7_alt;
            dec_op    = f7_alt ? ALU_SUB : ALU_ADD;
          end
          3'd5: begin
            dec_legal = f7_base | f7_alt;
            dec_op    = f7_alt ? ALU_SRA : ALU_SRL;
          end
          default: begin
            dec_legal = f7_base;
            dec_op    = f3_op(funct3);
          end
        endcase
      end
      OPC_OP_IMM: begin
        dec_use_imm = 1'b1;
        case (funct3)
          3'd1: begin
            dec_legal = f7_base;
            dec_op    = ALU_SLL;
          end
          3'd5: begin
            dec_legal = f7_base | f7_alt;
            dec_op    = f7_alt ? ALU_SRA : ALU_SRL;
          end
          default: begin
            dec_legal = 1'b1;
            dec_op    = f3_op(funct3);
          end
        endcase
      end
      default: begin
        dec_legal   = 1'b0;
        dec_use_imm = 1'b0;
        dec_op      = ALU_ADD;
      end
    endcase
  end

  alu_regfile_array u_array (
    .clk        (clk),
    .rst_b      (rst_b),
    .rs1_addr_i (rs1),
    .rs2_addr_i (rs2),
    .dbg_addr_i (bus.dbg_num),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .dbg_data_o (bus.dbg_data),
    .we_i       (bus.rd_we),
    .wr_addr_i  (rd),
    .wr_data_i  (bus.rd_data)
  );

  assign op_a  = rs1_data;
  assign op_b  = dec_use_imm ? imm : rs2_data;
  // For immediate shifts op_b[4:0] is inst[24:20], so one shamt path serves both forms.
  assign shamt = op_b[4:0];

  always_comb begin
    alu_res = '0;
    case (dec_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> shamt;
      ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
      default:  alu_res = '0;
    endcase
  end

  assign bus.rd_data = dec_legal ? alu_res : '0;
  assign bus.rd_we   = dec_legal & ~halted_q;
  assign bus.halted  = halted_q;

  assign halted_d = halted_q | (opcode == OPC_SYSTEM);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

endmodule

// File: tb/tb_alu_control_regfile.sv
// Bench for alu_control_regfile: directed program, asynchronous reset, then random RV32I
// OP/OP-IMM traffic checked by a scoreboard against an instruction-level reference model.
`timescale 1ns/100ps
module tb_alu_control_regfile;

  localparam int W = 66; // {halted, rd_we, rd_data, dbg_data}

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic rst_b  = 1'b0;

  alu_control_regfile_if bus ();

  alu_control_regfile dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  // Clock can be frozen to prove the reset acts without an edge.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  logic [31:0]  m_regs [32];
  logic         m_halted;
  logic [W-1:0] exp_q [$];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_halted = 1'b0;
  endtask

  // Instruction semantics straight from the ISA: legality, operands, plain arithmetic.
  task automatic ref_exec(input logic [31:0] in, output logic legal, output logic [31:0] res);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        is_r, alt;
    opc  = in[6:0];
    f3   = in[14:12];
    f7   = in[31:25];
    is_r = (opc == 7'h33);
    legal = 1'b0;
    res   = 32'h0;
    if (is_r)
      legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (opc == 7'h13)
      legal = (f3 == 3'd1) ? (f7 == 7'h00) :
              (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
    if (legal) begin
      a   = (in[19:15] == 5'd0) ? 32'h0 : m_regs[in[19:15]];
      b   = is_r ? ((in[24:20] == 5'd0) ? 32'h0 : m_regs[in[24:20]])
                 : {{20{in[31]}}, in[31:20]};
      alt = (f7 == 7'h20);
      case (f3)
        3'd0: res = (is_r && alt) ? a - b : a + b;
        3'd1: res = a << b[4:0];
        3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end
  endtask

  task automatic drive(input logic [31:0] in, input logic [4:0] dnum);
    logic        legal, we;
    logic [31:0] res;
    @(posedge clk);
    #1;
    bus.inst    = in;
    bus.dbg_num = dnum;
    ref_exec(in, legal, res);
    we = legal && !m_halted;
    exp_q.push_back({m_halted, we, (legal ? res : 32'h0), ((dnum == 5'd0) ? 32'h0 : m_regs[dnum])});
    if (we && in[11:7] != 5'd0) m_regs[in[11:7]] = res;
    if (in[6:0] == 7'h73) m_halted = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  f7;
    logic [4:0]  rs2, rs1, rd;
    logic [2:0]  f3;
    logic [11:0] imm12;
    logic [31:0] r;
    int          kind;
    kind  = $urandom_range(0, 9);
    rs1   = 5'($urandom_range(0, 31));
    rs2   = 5'($urandom_range(0, 31));
    rd    = 5'($urandom_range(0, 31));
    f3    = 3'($urandom_range(0, 7));
    f7    = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    imm12 = 12'($urandom());
    if (kind <= 3) begin
      if (f3 != 3'd0 && f3 != 3'd5) f7 = 7'h00;
      r = {f7, rs2, rs1, f3, rd, 7'h33};
    end else if (kind <= 7) begin
      if (f3 == 3'd1)      r = {7'h00, rs2, rs1, f3, rd, 7'h13};
      else if (f3 == 3'd5) r = {f7, rs2, rs1, f3, rd, 7'h13};
      else                 r = {imm12, rs1, f3, rd, 7'h13};
    end else if (kind == 8) begin
      f7 = 7'($urandom());
      r  = {f7, rs2, rs1, f3, rd, (($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13)};
    end else begin
      r = $urandom();
      if (r[6:0] == 7'h73) r[6:0] = 7'h03;
    end
    return r;
  endfunction

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("halted",   {31'b0, bus.halted}, {31'b0, e[65]});
        check("rd_we",    {31'b0, bus.rd_we},  {31'b0, e[64]});
        check("rd_data",  bus.rd_data,         e[63:32]);
        check("dbg_data", bus.dbg_data,        e[31:0]);
      end
    end
  end

  task automatic peek_reg(input string name, input logic [4:0] num, input logic [31:0] exp);
    @(posedge clk);
    #1;
    bus.dbg_num = num;
    #1;
    check(name, bus.dbg_data, exp);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bus.inst    = 32'h0;
    bus.dbg_num = 5'd0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("reset_halted", {31'b0, bus.halted}, 32'h0);
    bus.dbg_num = 5'd1;
    #1;
    check("reset_x1", bus.dbg_data, 32'h0);
    @(negedge clk);
    rst_b = 1'b1;

    // Directed program; each dbg_num reads back the previous instruction's destination.
    drive(32'h00500093, 5'd0);
    drive(32'hFFD00113, 5'd1);
    drive(32'h0020B1B3, 5'd2);
    drive(32'h0020A233, 5'd3);
    drive(32'h40115293, 5'd4);
    drive(32'h00115293, 5'd5);
    drive(32'h00700013, 5'd5);
    drive(32'h00000003, 5'd0);
    drive(32'h0000007F, 5'd1);
    drive(32'h00000073, 5'd2);
    drive(32'h00900093, 5'd1);
    drive(32'h00900093, 5'd1);
    @(negedge clk);
    @(negedge clk);

    peek_reg("dir_x0", 5'd0, 32'h0);
    peek_reg("dir_x1", 5'd1, 32'd5);
    peek_reg("dir_x2", 5'd2, 32'hFFFFFFFD);
    peek_reg("dir_x3", 5'd3, 32'd1);
    peek_reg("dir_x4", 5'd4, 32'd0);
    peek_reg("dir_x5", 5'd5, 32'h7FFFFFFE);
    check("dir_halted", {31'b0, bus.halted}, 32'h1);
    check("dir_halted_we", {31'b0, bus.rd_we}, 32'h0);

    // Asynchronous reset with the clock frozen.
    @(posedge clk);
    #2;
    clk_en = 1'b0;
    rst_b  = 1'b0;
    #1;
    check("async_halted", {31'b0, bus.halted}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      bus.dbg_num = 5'(i);
      #1;
      check("async_reg", bus.dbg_data, 32'h0);
    end
    clk_en = 1'b1;

    bus.inst = 32'h00900093;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.inst = 32'h0;
    rst_b    = 1'b1;
    model_reset();
    peek_reg("reset_ignores_inst", 5'd1, 32'h0);

    repeat (400) drive(rand_inst(), 5'($urandom_range(0, 31)));
    drive(32'h00100073, 5'($urandom_range(0, 31)));
    repeat (6) drive(rand_inst(), 5'($urandom_range(0, 31)));
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
